// File: rtl/cla_16bit_pkg.sv
// Shared constants and result bundle for the saturating 16-bit carry-lookahead adder.
package cla_16bit_pkg;

    localparam int WIDTH  = 16;
    localparam int GROUPS = WIDTH / 4;

    localparam logic [WIDTH-1:0] SAT_POS = 16'h7FFF;
    localparam logic [WIDTH-1:0] SAT_NEG = 16'h8000;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             v;
    } result_t;

    function automatic logic [WIDTH-1:0] sat_value(input logic neg);
        return neg ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/cla_16bit_cla_4bit.sv
// 4-bit carry-lookahead group: internal carries from bit generate/propagate,
// plus group P/G for the second-level lookahead unit.
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       pg,
    output logic       gg
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of cin; nothing ripples bit to bit.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign s  = p ^ c;
    assign pg = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_16bit.sv
// Saturating two's-complement add/subtract on a two-level 16-bit CLA,
// with sum, raw carry and overflow registered together (latency 1).
module cla_16bit
    import cla_16bit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             V
);

    logic [WIDTH-1:0]  bx;
    logic [WIDTH-1:0]  raw;
    logic [GROUPS-1:0] gp;
    logic [GROUPS-1:0] gg;
    logic [GROUPS:0]   gc;
    logic              ovf;
    result_t           nxt;
    result_t           q;

    // Subtraction is a + ~b + 1: invert b and feed sub in as the carry.
    assign bx = b ^ {WIDTH{sub}};

    genvar i;
    generate
        for (i = 0; i < GROUPS; i++) begin : g_grp
            cla_4bit u_grp (
                .a   (a[4*i +: 4]),
                .b   (bx[4*i +: 4]),
                .cin (gc[i]),
                .s   (raw[4*i +: 4]),
                .pg  (gp[i]),
                .gg  (gg[i])
            );
        end
    endgenerate

    // Second-level lookahead: group carries expanded, not chained.
    assign gc[0] = sub;
    assign gc[1] = gg[0] | (gp[0] & sub);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & sub);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & sub);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & sub);

    assign ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        // NOTE: assign every field a default first so no path leaves a latch.
        nxt      = '0;
        nxt.cout = gc[GROUPS];
        nxt.v    = ovf;
        nxt.sum  = ovf ? sat_value(a[WIDTH-1]) : raw;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignment for all registered state.
        if (!rst_n) q <= '0;
        else        q <= nxt;
    end

    assign sum  = q.sum;
    assign cout = q.cout;
    assign V    = q.v;

endmodule

// File: tb/tb_cla_16bit.sv
// Directed-vector bench for cla_16bit with hand-computed expected results.
module tb_cla_16bit;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        V;

    int checks = 0;
    int errors = 0;

    cla_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .sum   (sum),
        .cout  (cout),
        .V     (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] es, input logic ec, input logic ev);
        check({tag, ".sum"},  {16'h0, sum},  {16'h0, es});
        check({tag, ".cout"}, {31'h0, cout}, {31'h0, ec});
        check({tag, ".V"},    {31'h0, V},    {31'h0, ev});
    endtask

    // Drive on the falling edge, sample 1 time unit after the next rising edge.
    task automatic apply(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vs, input logic [15:0] es, input logic ec, input logic ev);
        @(negedge clk);
        a   = va;
        b   = vb;
        sub = vs;
        @(posedge clk);
        #1;
        check_out(tag, es, ec, ev);
    endtask

    initial begin
        rst_n = 1'b0;
        a     = 16'h1111;
        b     = 16'h2222;
        sub   = 1'b0;
        #12;
        check_out("reset", 16'h0000, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        //        tag           a         b         sub   sum       cout  V
        apply("add_20k_10k",  16'd20000, 16'd10000, 1'b0, 16'd30000, 1'b0, 1'b0);
        apply("sub_20k_10k",  16'd20000, 16'd10000, 1'b1, 16'd10000, 1'b1, 1'b0);
        apply("pos_sat",      16'h7FFF,  16'd100,   1'b0, 16'h7FFF,  1'b0, 1'b1);
        apply("neg_sat_add",  16'h8001,  16'hFB2E,  1'b0, 16'h8000,  1'b1, 1'b1);
        apply("neg_sat_sub",  16'h8000,  16'h0001,  1'b1, 16'h8000,  1'b1, 1'b1);
        apply("m1_plus_1",    16'hFFFF,  16'h0001,  1'b0, 16'h0000,  1'b1, 1'b0);
        apply("min_sub_min",  16'h8000,  16'h8000,  1'b1, 16'h0000,  1'b1, 1'b0);
        apply("zero_sub_min", 16'h0000,  16'h8000,  1'b1, 16'h7FFF,  1'b0, 1'b1);
        apply("full_prop",    16'hFFFF,  16'hFFFF,  1'b1, 16'h0000,  1'b1, 1'b0);
        apply("no_carry",     16'hFFFF,  16'h0000,  1'b0, 16'hFFFF,  1'b0, 1'b0);
        apply("alt_bits",     16'h5555,  16'h2AAA,  1'b0, 16'h7FFF,  1'b0, 1'b0);
        apply("borrow",       16'h1234,  16'h5678,  1'b1, 16'hBBBC,  1'b0, 1'b0);
        apply("grp_carry",    16'h0FFF,  16'h0001,  1'b0, 16'h1000,  1'b0, 1'b0);

        // Mid-stream asynchronous reset with outputs nonzero.
        apply("pre_reset",    16'd20000, 16'd10000, 1'b0, 16'd30000, 1'b0, 1'b0);
        @(negedge clk);
        a     = 16'h7FFF;
        b     = 16'h0001;
        sub   = 1'b0;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out("reset_hold", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_out("post_release", 16'h0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_out("first_after_rst", 16'h7FFF, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
